// File: rtl/csi_rx_stream_ctrl.sv
// Byte-clock sequencer between the CSI-2 receiver stream and the CDC FIFO write port.
// Holds the FIFO in reset, waits for it to settle, then admits whole frames only.
module csi_rx_stream_ctrl #(
  parameter int PHY_RST_CYCLES = 200000000,
  parameter int SETTLE_CYCLES  = 100000000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic        byte_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_status,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic        fifo_full,
  input  logic        fifo_wr_rst_busy,
  output logic        fifo_rst,
  output logic        fifo_wr_en,
  output logic        stream_active,
  output logic        overflow_sticky,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);

  typedef enum logic [2:0] {RST, SETTLE, WAIT_SOF, STREAM, DROP} state_t;

  localparam logic [CNT_WIDTH-1:0] RST_LAST    = CNT_WIDTH'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sof_ok;
  logic                 lost;
  logic                 sof_written;
  logic                 stop_sof;

  // tlast is observed only; line boundaries never change sequencing
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;

  assign sof_ok      = s_axis_tvalid & s_axis_tuser & enable & ~fifo_full;
  assign lost        = (state == STREAM) & s_axis_tvalid & fifo_full;
  assign stop_sof    = (state == STREAM) & s_axis_tvalid & s_axis_tuser & ~enable;
  assign sof_written = s_axis_tvalid & s_axis_tuser & fifo_wr_en;

  always_comb begin
    fifo_wr_en = 1'b0;
    case (state)
      WAIT_SOF, DROP: fifo_wr_en = sof_ok;
      STREAM:         fifo_wr_en = s_axis_tvalid & ~fifo_full & ~(s_axis_tuser & ~enable);
      default:        fifo_wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge byte_clock or posedge reset) begin
    if (reset) begin
      state           <= RST;
      cnt             <= '0;
      fifo_rst        <= 1'b1;
      stream_active   <= 1'b0;
      overflow_sticky <= 1'b0;
      frame_count     <= '0;
      drop_count      <= '0;
    end else begin
      case (state)
        RST: begin
          if (cnt == RST_LAST) begin
            state    <= SETTLE;
            fifo_rst <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          // any busy cycle restarts the settle window
          if (fifo_wr_rst_busy) cnt <= '0;
          else if (cnt == SETTLE_LAST) begin
            state <= WAIT_SOF;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        end
        WAIT_SOF, DROP: begin
          if (sof_ok) begin
            state         <= STREAM;
            stream_active <= 1'b1;
          end
        end
        STREAM: begin
          // overflow outranks the disable-at-SOF exit: the beat is lost either way
          if (lost) begin
            state         <= DROP;
            stream_active <= 1'b0;
          end else if (stop_sof) begin
            state         <= WAIT_SOF;
            stream_active <= 1'b0;
          end
        end
        default: begin
          state         <= RST;
          fifo_rst      <= 1'b1;
          stream_active <= 1'b0;
          cnt           <= '0;
        end
      endcase

      if (clear_status) begin
        frame_count     <= '0;
        drop_count      <= '0;
        overflow_sticky <= 1'b0;
      end else begin
        if (sof_written) frame_count <= frame_count + 16'd1;
        if (lost) begin
          overflow_sticky <= 1'b1;
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

endmodule
